// File: rtl/updown_sweep_ctrl.sv
// Sweeps an external up/down counter LO->HI->LO with endpoint dwells and
// watches the counter value every cycle for steps that disagree with the command.
module updown_sweep_ctrl #(
    parameter int WIDTH  = 4,
    parameter int LO     = 0,
    parameter int HI     = 15,
    parameter int DWELL  = 2,
    parameter int SWEEPS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] count_in,
    output logic             cnt_en,
    output logic             updown,
    output logic             busy,
    output logic             done,
    output logic [15:0]      sweep_idx,
    output logic             step_err
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        UP,
        DWELL_HI,
        DOWN,
        DWELL_LO,
        DONE
    } state_t;

    localparam int               DW_W    = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [DW_W-1:0]  DW_LOAD = DW_W'((DWELL > 0) ? DWELL - 1 : 0);
    localparam logic [WIDTH-1:0] LO_V    = WIDTH'(LO);
    localparam logic [WIDTH-1:0] LO_P1   = WIDTH'(LO + 1);
    localparam logic [WIDTH-1:0] LO_M1   = WIDTH'(LO - 1);
    localparam logic [WIDTH-1:0] HI_M1   = WIDTH'(HI - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           state;
    state_t           state_next;
    logic [DW_W-1:0]  dwell_cnt;
    logic [15:0]      sweep_next;
    logic             cnt_en_next;
    logic             updown_next;
    logic             clear_err;
    logic [WIDTH:0]   diff_lo;
    logic             below_lo;
    logic             near_lo;

    logic [WIDTH-1:0] count_p1;
    logic             cnt_en_p1;
    logic             updown_p1;
    logic             busy_p1;
    logic [WIDTH-1:0] exp_count;
    logic             step_bad;

    // Borrow of count_in - LO tells which side of LO the counter sits on.
    assign diff_lo  = {1'b0, count_in} - (WIDTH+1)'(LO);
    assign below_lo = diff_lo[WIDTH];
    assign near_lo  = below_lo ? (count_in == LO_M1) : (count_in == LO_P1);

    always_comb begin
        state_next = state;
        sweep_next = sweep_idx;
        clear_err  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_err  = 1'b1;
                    sweep_next = 16'd0;
                    state_next = (count_in == LO_V) ? UP : ALIGN;
                end
            end
            ALIGN: begin
                if (near_lo) state_next = (DWELL == 0) ? UP : DWELL_LO;
            end
            UP: begin
                if (count_in == HI_M1) state_next = (DWELL == 0) ? DOWN : DWELL_HI;
            end
            DWELL_HI: begin
                if (dwell_cnt == '0) state_next = DOWN;
            end
            DOWN: begin
                if (count_in == LO_P1) begin
                    sweep_next = sat_inc(sweep_idx);
                    if (SWEEPS != 0 && sweep_next == 16'(SWEEPS))
                        state_next = DONE;
                    else
                        state_next = (DWELL == 0) ? UP : DWELL_LO;
                end
            end
            DWELL_LO: begin
                if (dwell_cnt == '0) state_next = UP;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // An abort also discards a sweep that would have completed this cycle.
        if (stop && state != IDLE) begin
            state_next = IDLE;
            sweep_next = sweep_idx;
        end
    end

    always_comb begin
        cnt_en_next = (state_next == ALIGN) || (state_next == UP) || (state_next == DOWN);
        updown_next = updown;
        case (state_next)
            UP, DWELL_HI: updown_next = 1'b1;
            DOWN:         updown_next = 1'b0;
            ALIGN:        updown_next = below_lo;
            default:      updown_next = updown;
        endcase
    end

    assign exp_count = cnt_en_p1 ? (updown_p1 ? count_p1 + WIDTH'(1) : count_p1 - WIDTH'(1))
                                 : count_p1;
    assign step_bad  = busy_p1 && (state != IDLE) && (count_in != exp_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt_en    <= 1'b0;
            updown    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sweep_idx <= 16'd0;
            step_err  <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_next;
            cnt_en    <= cnt_en_next;
            updown    <= updown_next;
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
            sweep_idx <= sweep_next;
            if (clear_err)
                step_err <= 1'b0;
            else if (step_bad)
                step_err <= 1'b1;
            if ((state_next == DWELL_HI || state_next == DWELL_LO) && state_next != state)
                dwell_cnt <= DW_LOAD;
            else if (dwell_cnt != '0)
                dwell_cnt <= dwell_cnt - DW_W'(1);
        end
    end

    // Stage p1: command and counter value of the previous cycle for the step check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_en_p1 <= 1'b0;
            updown_p1 <= 1'b0;
            busy_p1   <= 1'b0;
        end else begin
            cnt_en_p1 <= cnt_en;
            updown_p1 <= updown;
            busy_p1   <= busy;
        end
    end

    always_ff @(posedge clk) begin
        count_p1 <= count_in;
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: behavioural counters close the loop, expected
// per-cycle outputs are queued with each stimulus step and compared a cycle later.
module tb_updown_sweep_ctrl;

    localparam int W  = 4;
    localparam int LO = 0;
    localparam int HI = 15;
    localparam int DW = 2;

    typedef struct {
        int c;
        int en;
        int ud;
        int b;
        int d;
        int idx;
        int err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;
    logic         skip = 1'b0, ld = 1'b0;
    logic [W-1:0] ld_val = '0;
    logic [W-1:0] count_a = '0;
    logic [W-1:0] count_b = '0;
    logic         cnt_en_a, updown_a, busy_a, done_a, err_a;
    logic         cnt_en_b, updown_b, busy_b, done_b, err_b;
    logic [15:0]  idx_a, idx_b;
    logic         sel = 1'b0;

    int    n_total = 0;
    int    n_bad   = 0;
    string phase   = "reset";
    exp_t  sb[$];

    updown_sweep_ctrl #(.WIDTH(W), .LO(LO), .HI(HI), .DWELL(DW), .SWEEPS(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .count_in(count_a),
        .cnt_en(cnt_en_a), .updown(updown_a), .busy(busy_a), .done(done_a),
        .sweep_idx(idx_a), .step_err(err_a)
    );

    updown_sweep_ctrl #(.WIDTH(W), .LO(LO), .HI(HI), .DWELL(0), .SWEEPS(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .count_in(count_b),
        .cnt_en(cnt_en_b), .updown(updown_b), .busy(busy_b), .done(done_b),
        .sweep_idx(idx_b), .step_err(err_b)
    );

    always #5 clk = ~clk;

    // Counter models: one step per enabled cycle, skip forces a double step.
    always @(posedge clk) begin
        if (ld)
            count_a <= ld_val;
        else if (cnt_en_a)
            count_a <= updown_a ? count_a + (skip ? 4'd2 : 4'd1)
                                : count_a - (skip ? 4'd2 : 4'd1);
    end

    always @(posedge clk) begin
        if (cnt_en_b) count_b <= updown_b ? count_b + 4'd1 : count_b - 4'd1;
    end

    wire [W-1:0] o_count = sel ? count_b  : count_a;
    wire         o_en    = sel ? cnt_en_b : cnt_en_a;
    wire         o_ud    = sel ? updown_b : updown_a;
    wire         o_busy  = sel ? busy_b   : busy_a;
    wire         o_done  = sel ? done_b   : done_a;
    wire [15:0]  o_idx   = sel ? idx_b    : idx_a;
    wire         o_err   = sel ? err_b    : err_a;

    task automatic chk(input string tag, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic compare_front();
        exp_t x;
        if (sb.size() == 0) return;
        x = sb.pop_front();
        chk({phase, ".count"}, int'(o_count), x.c);
        chk({phase, ".cnt_en"}, int'(o_en), x.en);
        if (x.ud >= 0) chk({phase, ".updown"}, int'(o_ud), x.ud);
        chk({phase, ".busy"}, int'(o_busy), x.b);
        chk({phase, ".done"}, int'(o_done), x.d);
        chk({phase, ".sweep_idx"}, int'(o_idx), x.idx);
        chk({phase, ".step_err"}, int'(o_err), x.err);
    endtask

    // Drive inputs for the next edge and queue the outputs expected after it.
    task automatic step(input int st, input int sp, input int sk, input int c, input int en,
                        input int ud, input int b, input int d, input int idx, input int err);
        exp_t x;
        @(negedge clk);
        compare_front();
        if (sel) begin
            start_b = (st != 0);
            stop_b  = (sp != 0);
        end else begin
            start_a = (st != 0);
            stop_a  = (sp != 0);
        end
        skip = (sk != 0);
        x = '{c, en, ud, b, d, idx, err};
        sb.push_back(x);
    endtask

    task automatic flush();
        @(negedge clk);
        compare_front();
        start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0; skip = 1'b0;
    endtask

    task automatic set_count(input int v);
        @(negedge clk);
        ld = 1'b1;
        ld_val = W'(v);
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".cnt_en"}, int'(cnt_en_a), 0);
        chk({tag, ".updown"}, int'(updown_a), 0);
        chk({tag, ".busy"}, int'(busy_a), 0);
        chk({tag, ".done"}, int'(done_a), 0);
        chk({tag, ".sweep_idx"}, int'(idx_a), 0);
        chk({tag, ".step_err"}, int'(err_a), 0);
    endtask

    task automatic up_run(input int st_first, input int idx, input int last);
        for (int c = LO; c <= last; c++)
            step((c == LO) ? st_first : 0, 0, 0, c, 1, 1, 1, 0, idx, 0);
    endtask

    task automatic dwell_hi(input int idx);
        repeat (DW) step(0, 0, 0, HI, 0, 1, 1, 0, idx, 0);
    endtask

    task automatic down_run(input int idx);
        for (int c = HI; c >= LO + 1; c--)
            step(0, 0, 0, c, 1, 0, 1, 0, idx, 0);
    endtask

    task automatic dwell_lo(input int idx);
        repeat (DW) step(0, 0, 0, LO, 0, 0, 1, 0, idx, 0);
    endtask

    task automatic run_sweeps(input int st_first);
        up_run(st_first, 0, HI - 1);
        dwell_hi(0);
        down_run(0);
        dwell_lo(1);
        up_run(0, 1, HI - 1);
        dwell_hi(1);
        down_run(1);
        step(0, 0, 0, LO, 0, 0, 1, 1, 2, 0);
        repeat (2) step(0, 0, 0, LO, 0, -1, 0, 0, 2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        #2 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        phase = "sweep";
        run_sweeps(1);
        flush();

        phase = "align";
        set_count(7);
        step(1, 0, 0, 7, 1, 0, 1, 0, 0, 0);
        for (int c = 6; c >= 1; c--) step(0, 0, 0, c, 1, 0, 1, 0, 0, 0);
        dwell_lo(0);
        run_sweeps(0);
        flush();

        phase = "stop";
        up_run(1, 0, HI - 1);
        dwell_hi(0);
        down_run(0);
        dwell_lo(1);
        up_run(0, 1, 9);
        step(0, 1, 0, 10, 0, -1, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 10, 0, -1, 0, 0, 1, 0);
        flush();

        phase = "skip";
        set_count(0);
        up_run(1, 0, 5);
        step(0, 0, 1, 7, 1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 8, 1, 1, 1, 0, 0, 1);
        step(0, 0, 0, 9, 1, 1, 1, 0, 0, 1);
        step(0, 1, 0, 10, 0, -1, 0, 0, 0, 1);
        step(0, 0, 0, 10, 0, -1, 0, 0, 0, 1);
        step(1, 0, 0, 10, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 9, 0, -1, 0, 0, 0, 0);
        step(0, 0, 0, 9, 0, -1, 0, 0, 0, 0);
        flush();

        phase = "rst_mid";
        set_count(0);
        up_run(1, 0, HI - 1);
        dwell_hi(0);
        for (int c = HI; c >= 12; c--) step(0, 0, 0, c, 1, 0, 1, 0, 0, 0);
        flush();
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        @(negedge clk);
        check_zero("rst_held");
        chk("rst_held.count", int'(count_a), 12);
        rst = 1'b0;

        phase = "continuous";
        sel = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int c = LO; c <= HI - 1; c++)
                step((k == 0 && c == LO) ? 1 : 0, 0, 0, c, 1, 1, 1, 0, k, 0);
            for (int c = HI; c >= LO + 1; c--)
                step(0, 0, 0, c, 1, 0, 1, 0, k, 0);
        end
        for (int c = LO; c <= 3; c++) step(0, 0, 0, c, 1, 1, 1, 0, 3, 0);
        step(0, 1, 0, 4, 0, -1, 0, 0, 3, 0);
        repeat (2) step(0, 0, 0, 4, 0, -1, 0, 0, 3, 0);
        flush();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Drives the control inputs of an up/down counter. It sweeps the counter LO→HI→LO for a set number of sweeps, dwelling at each endpoint.
- Reads the counter output back every cycle and flags any step that does not match the command it issued.
- It is the driver/reader end of the counter interface: it consumes `count` and produces `updown` plus a count enable. It sits between the sequencing logic and any up/down counter with an enable input.

Parameters:
- WIDTH, 4, counter width in bits.
- LO, 0, lower sweep endpoint; requires HI − LO ≥ 2.
- HI, 15, upper sweep endpoint; HI ≤ 2^WIDTH − 1.
- DWELL, 2, cycles the counter is held at each endpoint; 0 means no hold.
- SWEEPS, 2, number of full up+down sweeps; 0 means run continuously until stop.

Ports:
- clk, in, 1, clock; all logic is on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle request; sampled only in IDLE.
- stop, in, 1, abort; honoured in any non-IDLE state.
- count_in, in, WIDTH, counter output, fed back from the counter.
- cnt_en, out, 1, counter enable (registered).
- updown, out, 1, direction to the counter: 1 = up, 0 = down (registered).
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse when the final sweep completes.
- sweep_idx, out, 16, number of completed sweeps in the current run.
- step_err, out, 1, sticky step-mismatch flag.

Behaviour:
- Reset (async): state=IDLE; cnt_en=0, updown=0, busy=0, done=0, sweep_idx=0, step_err=0.
- Counter model: a value applied on cnt_en/updown in cycle t changes count_in at t+1.
- All outputs are registered and derived from the next state.
- States: IDLE, ALIGN, UP, DWELL_HI, DOWN, DWELL_LO, DONE.
- IDLE: cnt_en=0.
  - start=1 and count_in==LO → UP.
  - start=1 and count_in!=LO → ALIGN.
  - start clears step_err and sweep_idx.
- ALIGN: cnt_en=1, updown=(count_in<LO).
  - Leave when count_in is one step from LO → DWELL_LO, or UP if DWELL=0.
  - The remaining step lands the counter on LO; no sweep is counted.
- UP: cnt_en=1, updown=1.
  - count_in==HI−1 → DWELL_HI, or DOWN if DWELL=0.
- DWELL_HI: cnt_en=0; updown holds 1. After DWELL cycles → DOWN.
- DOWN: cnt_en=1, updown=0.
  - count_in==LO+1 → sweep complete: sweep_idx += 1 (saturates at 0xFFFF).
  - If SWEEPS!=0 and the new sweep_idx == SWEEPS → DONE.
  - Otherwise → DWELL_LO, or UP if DWELL=0.
- DWELL_LO: cnt_en=0. After DWELL cycles → UP.
- DONE: lasts one cycle; done=1, cnt_en=0; → IDLE.
- stop: from any non-IDLE state the next state is IDLE; cnt_en=0 next cycle; no done pulse; sweep_idx is kept.
- Simultaneous events:
  - stop wins over every transition, including the final sweep completion (no done pulse).
  - start outside IDLE is ignored.
- Dwell counter is internal, $clog2(DWELL+1) bits, and reloads on dwell entry.
- Step checker, active when the previous cycle had busy=1; it compares against count_in registered one cycle earlier:
  - previous cnt_en=1 → expect count_in == prev ± 1 per previous updown, modulo 2^WIDTH.
  - previous cnt_en=0 → expect count_in == prev.
  - Mismatch sets step_err=1; it stays set until rst or an accepted start.
  - Checker is disabled in IDLE.
- Reset mid-operation: all outputs return to reset values immediately; the counter stops being commanded.

Test Plan:
- WIDTH=4, LO=0, HI=15, DWELL=2, SWEEPS=2; count starts at 0; start pulse → count 0→15, held 15 for 3 samples, 15→0, dwell, second sweep; done pulses once, sweep_idx=2, step_err=0, busy low afterwards.
- Start with the counter at 7 → ALIGN drives updown=0 until count=0, then normal sweep; sweep_idx counts only full sweeps.
- stop asserted while count=9 in UP → cnt_en=0 next cycle, count frozen at 10, state IDLE, done never asserted, sweep_idx unchanged.
- Counter model forced to skip (count 5→7 with cnt_en=1, up) → step_err=1 next cycle, stays 1; next accepted start clears it.
- DWELL=0, SWEEPS=0 → continuous triangle 0..15..0 with no hold cycles; sweep_idx increments every 30 cycles; only stop ends the run.
- rst asserted mid-DOWN → cnt_en, updown, busy, done, sweep_idx, step_err all 0 without waiting for a clock edge.
